// File: rtl/cpu_rf_pkg.sv
// Shared register-file types: architectural index names and the index-map helper.
package cpu_rf_pkg;

   typedef logic [3:0] reg_sel_t;

   localparam reg_sel_t REG_SP = 4'd13;
   localparam reg_sel_t REG_LR = 4'd14;
   localparam reg_sel_t REG_PC = 4'd15;

   // Writable storage exists only for the low GPRs, SP and LR; PC is read-only.
   function automatic logic is_mapped(input reg_sel_t sel, input int num_gpr);
      return (int'(sel) < num_gpr) || (sel == REG_SP) || (sel == REG_LR);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: one busy bit per writable register, issue-set beats return-clear.
module rf_scoreboard
   import cpu_rf_pkg::*;
#(
   parameter int NUM_GPR = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_set_en,
   input  reg_sel_t    i_set_sel,
   input  logic        i_clr_en,
   input  reg_sel_t    i_clr_sel,
   output logic [15:0] o_busy_nxt,
   output logic        o_ld_pending
);

   logic [15:0] r_busy;
   logic        r_pend;

   // Set is applied last so a new load to the returning register stays outstanding.
   always_comb begin
      o_busy_nxt = r_busy;
      if (i_clr_en && is_mapped(i_clr_sel, NUM_GPR)) o_busy_nxt[i_clr_sel] = 1'b0;
      if (i_set_en && is_mapped(i_set_sel, NUM_GPR)) o_busy_nxt[i_set_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
         r_pend <= 1'b0;
      end else begin
         r_busy <= o_busy_nxt;
         r_pend <= |o_busy_nxt;
      end
   end

   assign o_ld_pending = r_pend;

endmodule

// File: rtl/regfile_bypass_sb.sv
// Thumb-style register file with two write ports, bypassed registered reads,
// load scoreboard hazard flags and a read-side stall hold.
module regfile_bypass_sb
   import cpu_rf_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter int          NUM_GPR = 8,
   parameter int          NUM_RD  = 2,
   parameter logic [31:0] SP_RST  = 32'h1ffe
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_i,
   input  logic                     w0_en,
   input  logic [3:0]               w0_sel,
   input  logic [DATA_W-1:0]        w0_data,
   input  logic                     w1_en,
   input  logic [3:0]               w1_sel,
   input  logic [DATA_W-1:0]        w1_data,
   input  logic                     sp_wr_en,
   input  logic [DATA_W-1:0]        sp_in,
   input  logic                     ld_issue_en,
   input  logic [3:0]               ld_issue_sel,
   input  logic [DATA_W-1:0]        pc_i,
   input  logic [NUM_RD*4-1:0]      rd_sel,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_hazard,
   output logic [DATA_W-1:0]        sp_o,
   output logic                     ld_pending_o
);

   logic [DATA_W-1:0] w_next [16];
   logic [DATA_W-1:0] w_cur  [16];
   logic [15:0]       w_busy_nxt;

   rf_scoreboard #(.NUM_GPR(NUM_GPR)) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_set_en    (ld_issue_en),
      .i_set_sel   (ld_issue_sel),
      .i_clr_en    (w1_en),
      .i_clr_sel   (w1_sel),
      .o_busy_nxt  (w_busy_nxt),
      .o_ld_pending(ld_pending_o)
   );

   for (genvar j = 0; j < 15; j++) begin : g_reg
      localparam reg_sel_t IDX = reg_sel_t'(j);
      if (is_mapped(IDX, NUM_GPR)) begin : g_map
         logic [DATA_W-1:0] r_q;
         logic [DATA_W-1:0] w_d;

         // Priority: dedicated SP port, then ALU (younger), then load return.
         always_comb begin
            w_d = r_q;
            if (IDX == REG_SP && sp_wr_en)  w_d = sp_in;
            else if (w0_en && w0_sel == IDX) w_d = w0_data;
            else if (w1_en && w1_sel == IDX) w_d = w1_data;
         end

         always_ff @(posedge clk) begin
            if (rst) r_q <= (IDX == REG_SP) ? DATA_W'(SP_RST) : '0;
            else     r_q <= w_d;
         end

         assign w_next[j] = w_d;
         assign w_cur[j]  = r_q;
      end else begin : g_unm
         assign w_next[j] = '0;
         assign w_cur[j]  = '0;
      end
   end

   // Index 15 reads the live PC; it never has storage.
   assign w_next[15] = pc_i;
   assign w_cur[15]  = pc_i;
   assign sp_o       = w_cur[REG_SP];

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      reg_sel_t          w_sel;
      logic [DATA_W-1:0] r_data;
      logic              r_hz;

      assign w_sel = rd_sel[4*i +: 4];

      always_ff @(posedge clk) begin
         if (rst) begin
            r_data <= '0;
            r_hz   <= 1'b0;
         end else if (!stall_i) begin
            r_data <= w_next[w_sel];
            r_hz   <= w_busy_nxt[w_sel];
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = r_data;
      assign rd_hazard[i]                = r_hz;
   end

endmodule
